fifo_sync_fwft: RTL and testbench
=================================

# fifo_sync_fwft

Parametrised synchronous first-word-fall-through FIFO with registered output, occupancy count, almost-full flag and synchronous flush. It is the general successor to the fixed 2-entry, 9-bit input buffer in front of the compressor core. It carries the same i_en/i_rdy → o_en/o_rdy handshake, but at any power-of-two depth and any data width. It also gives upstream producers early back-pressure, and lets the controller discard buffered data between streams.

## Interface
- DW, 9: data width in bits.
- AW, 1: log2 of depth; capacity DEPTH = 2**AW entries. AW must be ≥ 1.
- AFULL_TH, 2**AW-1: o_afull asserts when occupancy ≥ AFULL_TH. Legal range is 1..2**AW.
- clk  in  1  single clock; all logic samples on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  synchronous clear of all contents; active-high, one cycle is enough.
- i_rdy  out  1  FIFO can accept a word this cycle.
- i_en  in  1  producer presents a word. The write happens only when i_en & i_rdy.
- i_data  in  DW  input word.
- o_rdy  in  1  consumer accepts the word. The read happens only when o_en & o_rdy.
- o_en  out  1  o_data is valid.
- o_data  out  DW  head word, driven directly from a register.
- o_count  out  AW+1  number of stored words, 0..2**AW.
- o_afull  out  1  registered flag, o_count ≥ AFULL_TH.

## Operation
- Transfer rules: wr = i_en & i_rdy; rd = o_en & o_rdy. An i_en seen while i_rdy=0 is ignored. It is not an error and has no side effect.
- Ordering is strict FIFO. No word is lost or duplicated.
- First-word-fall-through: the head word sits on o_data with o_en=1 without needing a read. After each rd, the next word is presented on the following cycle.
- i_rdy = (count < 2**AW), taken from registered state. There is no combinational path from o_rdy to i_rdy, or from i_data/i_en to o_data/o_en.
- When full, a read and a write in the same cycle cannot happen, because i_rdy=0. The read proceeds and i_rdy rises on the next cycle.
- When neither empty nor full, a simultaneous wr and rd leaves the count unchanged and sustains one word per cycle.
- When empty, a wr loads o_data directly. o_en is 1 on the next cycle.
- Pointers are AW bits and wrap modulo 2**AW. The count is AW+1 bits and never exceeds 2**AW.
- Flush: on the edge where flush=1, the count, pointers and o_en are cleared. A wr or rd presented in the same cycle is discarded; flush wins. o_data holds its last value.
- Priority: rst > flush > normal operation.

## Timing
- Reset values after the rst edge: i_rdy=1, o_en=0, o_data=0, o_count=0, o_afull=0.
- A rst asserted mid-stream clears everything on that edge. State after the edge is identical to a cold reset.
- Write-to-output latency is 1 cycle: a wr at edge N into an empty FIFO gives o_en=1 and o_data=i_data after edge N.
- Throughput is 1 word per cycle in steady state, with both sides continuously enabled.
- o_count and o_afull update on the same edge as the wr/rd that changes them.
- After flush, o_en=0 and i_rdy=1 on the next cycle.

## Structure
- No shared package types are needed. The depth/width math uses local parameters only: DEPTH = 2**AW.
- One natural sub-module: fifo_sync_ram, a DEPTH×DW array with a registered write and an asynchronous read.
  - The head is prefetched from it into the o_data register.
  - It maps to distributed RAM or flops; no block-RAM read latency appears at the ports.
- The top level holds the pointers, the count, the prefetch/valid logic and the almost-full register.

## Test plan
- Reset, then DW=9, AW=2. Write 0x101, 0x102, 0x103, 0x104 with o_rdy=0 → i_rdy drops after the 4th write, o_count=4, o_afull=1 at count 3. A 5th i_en is ignored.
- Drain the above with o_rdy=1 → o_data reads 0x101..0x104 on consecutive cycles, then o_en=0 and o_count=0.
- i_en=1 and o_rdy=1 every cycle with an incrementing pattern for 100 words → 1 word/cycle, output sequence matches input, o_count stays constant.
- Fill to full, then assert i_en and o_rdy together → the cycle's write is refused, the read happens, i_rdy=1 on the next cycle, and the next write is accepted.
- With 3 words stored, assert flush together with i_en=1 and o_rdy=1 → o_en=0, o_count=0 next cycle, no word emitted. A subsequent write of 0x055 appears as the next o_data.
- Assert rst during a random streaming run → all outputs take reset values the cycle after. Post-reset traffic is ordered with no stale words.

Source files
------------

// File: rtl/fifo_sync_fwft_pkg.sv
// Shared definitions for the first-word-fall-through FIFO: the per-cycle
// transfer kind decoded from the write and read strobes.
package fifo_sync_fwft_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WR    = 2'b01,
        OP_RD    = 2'b10,
        OP_WR_RD = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e decode_op(input logic wr, input logic rd);
        return fifo_op_e'({rd, wr});
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// DEPTH x DW storage array: registered write, asynchronous read, so the
// head prefetch in the top level sees no read latency.
module fifo_sync_ram #(
    parameter int DW = 9,
    parameter int AW = 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_fwft.sv
// Synchronous FWFT FIFO: the head word is held in a register on o_data,
// refilled from the array (or straight from i_data) whenever it moves on.
module fifo_sync_fwft
    import fifo_sync_fwft_pkg::*;
#(
    parameter int DW       = 9,
    parameter int AW       = 1,
    parameter int AFULL_TH = 2**AW - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    output logic          i_rdy,
    input  logic          i_en,
    input  logic [DW-1:0] i_data,
    input  logic          o_rdy,
    output logic          o_en,
    output logic [DW-1:0] o_data,
    output logic [AW:0]   o_count,
    output logic          o_afull
);

    localparam int DEPTH = 2**AW;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AFULL_C = (AW+1)'(AFULL_TH);
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    // Handshake: a word moves only on a clock edge where valid and ready are
    // both high (wr = i_en & i_rdy, rd = o_en & o_rdy); valid never waits on
    // ready, and both ready/valid outputs come from registered state only.
    logic          wr, rd;
    fifo_op_e      op;
    logic [AW-1:0] wr_ptr, rd_ptr, next_rd_addr;
    logic [AW:0]   count, count_next;
    logic [DW-1:0] head_next, ram_rdata;

    assign i_rdy        = (count < DEPTH_C);
    assign wr           = i_en & i_rdy;
    assign rd           = o_en & o_rdy;
    assign op           = decode_op(wr, rd);
    assign next_rd_addr = rd_ptr + PTR_ONE;
    assign o_count      = count;

    // The array holds every stored word including the head; the head
    // register is a copy of mem[rd_ptr]. A word written into an empty (or
    // emptying) FIFO is not in the array yet, so it bypasses from i_data.
    always_comb begin
        count_next = count;
        head_next  = o_data;
        unique case (op)
            OP_WR: begin
                count_next = count + CNT_ONE;
                if (count == '0) head_next = i_data;
            end
            OP_RD: begin
                count_next = count - CNT_ONE;
                if (count > CNT_ONE) head_next = ram_rdata;
            end
            OP_WR_RD: begin
                head_next = (count == CNT_ONE) ? i_data : ram_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_en    <= 1'b0;
            o_data  <= '0;
            o_afull <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_en    <= 1'b0;
            o_afull <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd) rd_ptr <= next_rd_addr;
            count   <= count_next;
            o_en    <= (count_next != '0);
            o_data  <= head_next;
            o_afull <= (count_next >= AFULL_C);
        end
    end

    fifo_sync_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr & ~flush & ~rst),
        .waddr (wr_ptr),
        .wdata (i_data),
        .raddr (next_rd_addr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Bench for fifo_sync_fwft (DW=9, AW=2): directed vector table, then
// scoreboarded streaming, full/flush corners and a mid-stream reset.
module tb_fifo_sync_fwft;

    localparam int DW = 9;
    localparam int AW = 2;

    logic          clk;
    logic          rst, flush, i_en, o_rdy;
    logic [DW-1:0] i_data;
    logic          i_rdy, o_en, o_afull;
    logic [DW-1:0] o_data;
    logic [AW:0]   o_count;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic          rst, flush, i_en, o_rdy;
        logic [DW-1:0] i_data;
        logic          x_rdy, x_en, chk_data, x_af;
        logic [DW-1:0] x_data;
        logic [AW:0]   x_cnt;
    } vec_t;

    vec_t vecs[$];

    fifo_sync_fwft #(.DW(DW), .AW(AW), .AFULL_TH(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .i_rdy   (i_rdy),
        .i_en    (i_en),
        .i_data  (i_data),
        .o_rdy   (o_rdy),
        .o_en    (o_en),
        .o_data  (o_data),
        .o_count (o_count),
        .o_afull (o_afull)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input int r, input int f, input int en, input int d, input int rdy,
                       input int xr, input int xe, input int cd, input int xd,
                       input int xc, input int xa);
        vec_t v;
        v.rst = r[0]; v.flush = f[0]; v.i_en = en[0]; v.i_data = DW'(d); v.o_rdy = rdy[0];
        v.x_rdy = xr[0]; v.x_en = xe[0]; v.chk_data = cd[0]; v.x_data = DW'(xd);
        v.x_cnt = (AW+1)'(xc); v.x_af = xa[0];
        vecs.push_back(v);
    endtask

    task automatic apply_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        @(negedge clk);
        rst = v.rst; flush = v.flush; i_en = v.i_en; i_data = v.i_data; o_rdy = v.o_rdy;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d i_rdy", idx), int'(i_rdy), int'(v.x_rdy));
        chk($sformatf("v%0d o_en", idx), int'(o_en), int'(v.x_en));
        chk($sformatf("v%0d o_count", idx), int'(o_count), int'(v.x_cnt));
        chk($sformatf("v%0d o_afull", idx), int'(o_afull), int'(v.x_af));
        if (v.chk_data) chk($sformatf("v%0d o_data", idx), int'(o_data), int'(v.x_data));
    endtask

    // driver + scoreboard: one cycle of traffic, model updated from the handshake
    int rd_words = 0;

    task automatic sb_cycle(input int r, input int en, input int d, input int rdy);
        logic do_wr, do_rd;
        @(negedge clk);
        rst = r[0]; flush = 1'b0; i_en = en[0]; i_data = DW'(d); o_rdy = rdy[0];
        do_wr = i_en & i_rdy;
        do_rd = o_en & o_rdy;
        if (r != 0) begin
            exp_q.delete();
        end else begin
            if (do_rd) begin
                if (exp_q.size() == 0) begin
                    chk("sb unexpected word", int'(o_data), -1);
                end else begin
                    chk("sb o_data", int'(o_data), int'(exp_q.pop_front()));
                    rd_words++;
                end
            end
            if (do_wr) exp_q.push_back(i_data);
        end
        @(posedge clk);
        #1;
        chk("sb o_count", int'(o_count), exp_q.size());
        chk("sb o_en", int'(o_en), int'(exp_q.size() != 0));
        chk("sb i_rdy", int'(i_rdy), int'(exp_q.size() < 4));
        chk("sb o_afull", int'(o_afull), int'(exp_q.size() >= 3));
        if (r != 0) chk("sb reset o_data", int'(o_data), 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) sb_cycle(0, 0, 0, 1);
        chk("drain empty", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; i_en = 1'b0; o_rdy = 1'b0; i_data = '0;

        //  rst f  en data   rdy | rdy en cd data  cnt af
        add(1, 0, 0, 'h000, 0,   1, 0, 1, 'h000, 0, 0);
        add(0, 0, 1, 'h101, 0,   1, 1, 1, 'h101, 1, 0);
        add(0, 0, 1, 'h102, 0,   1, 1, 1, 'h101, 2, 0);
        add(0, 0, 1, 'h103, 0,   1, 1, 1, 'h101, 3, 1);
        add(0, 0, 1, 'h104, 0,   0, 1, 1, 'h101, 4, 1);
        add(0, 0, 1, 'h1FF, 0,   0, 1, 1, 'h101, 4, 1);
        add(0, 0, 0, 'h000, 1,   1, 1, 1, 'h102, 3, 1);
        add(0, 0, 0, 'h000, 1,   1, 1, 1, 'h103, 2, 0);
        add(0, 0, 0, 'h000, 1,   1, 1, 1, 'h104, 1, 0);
        add(0, 0, 0, 'h000, 1,   1, 0, 0, 'h000, 0, 0);
        add(0, 0, 1, 'h0A1, 0,   1, 1, 1, 'h0A1, 1, 0);
        add(0, 0, 1, 'h0A2, 0,   1, 1, 1, 'h0A1, 2, 0);
        add(0, 0, 1, 'h0A3, 0,   1, 1, 1, 'h0A1, 3, 1);
        add(0, 0, 1, 'h0A4, 0,   0, 1, 1, 'h0A1, 4, 1);
        add(0, 0, 1, 'h0A5, 1,   1, 1, 1, 'h0A2, 3, 1);
        add(0, 0, 1, 'h0A6, 0,   0, 1, 1, 'h0A2, 4, 1);
        add(0, 0, 0, 'h000, 1,   1, 1, 1, 'h0A3, 3, 1);
        add(0, 0, 0, 'h000, 1,   1, 1, 1, 'h0A4, 2, 0);
        add(0, 0, 0, 'h000, 1,   1, 1, 1, 'h0A6, 1, 0);
        add(0, 0, 0, 'h000, 1,   1, 0, 0, 'h000, 0, 0);
        add(0, 0, 1, 'h011, 0,   1, 1, 1, 'h011, 1, 0);
        add(0, 0, 1, 'h022, 0,   1, 1, 1, 'h011, 2, 0);
        add(0, 0, 1, 'h033, 0,   1, 1, 1, 'h011, 3, 1);
        add(0, 1, 1, 'h044, 1,   1, 0, 0, 'h000, 0, 0);
        add(0, 0, 1, 'h055, 0,   1, 1, 1, 'h055, 1, 0);
        add(0, 0, 0, 'h000, 1,   1, 0, 0, 'h000, 0, 0);
        add(0, 0, 1, 'h066, 0,   1, 1, 1, 'h066, 1, 0);
        add(0, 0, 1, 'h077, 1,   1, 1, 1, 'h077, 1, 0);
        add(0, 0, 0, 'h000, 1,   1, 0, 0, 'h000, 0, 0);

        for (int i = 0; i < vecs.size(); i++) apply_vec(i);

        // continuous streaming: after one fill cycle every cycle moves a word
        rd_words = 0;
        for (int i = 0; i < 101; i++) sb_cycle(0, 1, (i + 1) & 'h1FF, 1);
        chk("stream words read", rd_words, 100);
        drain();

        // random traffic with a reset in the middle
        for (int i = 0; i < 200; i++)
            sb_cycle((i == 80) ? 1 : 0, int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 511)), int'($urandom_range(0, 1)));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
